// File: rtl/udp_rx_decoder_if.sv
// UDP receive decoder bus: segment words in, decoded header/payload/status out.
// Latency: n/a (signal bundle only).
// Backpressure: none; the decoder side never stalls the word stream.
interface udp_rx_decoder_if #(
  parameter int NUM_PORTS = 4
);
  logic [31:0]            data;
  logic                   start;
  logic [31:0]            src_ip;
  logic [31:0]            dest_ip;
  logic [16*NUM_PORTS-1:0] port_tbl;
  logic [15:0]            src_port_udp;
  logic [15:0]            dest_port_udp;
  logic [15:0]            len_udp_data;
  logic [31:0]            data_udp_out;
  logic                   wr_en_udp;
  logic [3:0]             byte_en;
  logic [NUM_PORTS-1:0]   port_hit;
  logic                   ok_udp;
  logic                   fin_udp;
  logic [2:0]             err_code;

  modport master (
    output data, start, src_ip, dest_ip, port_tbl,
    input  src_port_udp, dest_port_udp, len_udp_data, data_udp_out, wr_en_udp,
           byte_en, port_hit, ok_udp, fin_udp, err_code
  );

  modport slave (
    input  data, start, src_ip, dest_ip, port_tbl,
    output src_port_udp, dest_port_udp, len_udp_data, data_udp_out, wr_en_udp,
           byte_en, port_hit, ok_udp, fin_udp, err_code
  );
endinterface

// File: rtl/udp_rx_decoder.sv
// Decodes a UDP segment: header capture, payload forwarding, length/checksum/port checks.
// Latency: payload word out 1 cycle after sampling; fin_udp 2 cycles after the last accepted word.
// Backpressure: none; payload words must be consumed on every wr_en_udp.
module udp_rx_decoder #(
  parameter int NUM_PORTS = 4,
  parameter int MAX_LEN   = 1480,
  parameter bit CHK_EN    = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  udp_rx_decoder_if.slave bus
);

  typedef enum logic [2:0] {IDLE, HDR1, PAYLOAD, CHECK, DONE} state_t;

  state_t               state;
  logic [31:0]          acc;
  logic [15:0]          cnt;
  logic [15:0]          csum_rx;
  logic [1:0]           rem;

  logic [NUM_PORTS-1:0] hit_nxt;
  logic [31:0]          w0_sum;
  logic [15:0]          len_f;
  logic [15:0]          words;
  logic [31:0]          pay_m;
  logic [31:0]          pay_mask;
  logic [3:0]           be_last;
  logic [16:0]          fold1;
  logic [15:0]          fold2;
  logic [2:0]           err_fin;

  // Destination-port match against every table entry (multi-hot allowed).
  always_comb begin
    hit_nxt = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      hit_nxt[k] = (bus.port_tbl[16*k +: 16] == bus.data[15:0]);
    end
  end

  // Pseudo-header plus header word 0 seeds the accumulator; HDR1 length math; final-word masking.
  always_comb begin
    w0_sum = {16'b0, bus.src_ip[31:16]}  + {16'b0, bus.src_ip[15:0]}
           + {16'b0, bus.dest_ip[31:16]} + {16'b0, bus.dest_ip[15:0]}
           + 32'h0000_0011
           + {16'b0, bus.data[31:16]}    + {16'b0, bus.data[15:0]};
    len_f  = bus.data[31:16];
    // ceil((len-8)/4) == (len-5)>>2, only used when len > 8
    words  = (len_f - 16'd5) >> 2;
    case (rem)
      2'd1:    begin be_last = 4'b1000; pay_mask = 32'hFF00_0000; end
      2'd2:    begin be_last = 4'b1100; pay_mask = 32'hFFFF_0000; end
      2'd3:    begin be_last = 4'b1110; pay_mask = 32'hFFFF_FF00; end
      default: begin be_last = 4'b1111; pay_mask = 32'hFFFF_FFFF; end
    endcase
    pay_m = (cnt == 16'd1) ? (bus.data & pay_mask) : bus.data;
  end

  // End-around carry folded twice, then first-error-wins status resolution.
  always_comb begin
    fold1 = {1'b0, acc[31:16]} + {1'b0, acc[15:0]};
    fold2 = fold1[15:0] + {15'b0, fold1[16]};
    if (bus.err_code != 3'd0)
      err_fin = bus.err_code;
    else if (CHK_EN && (csum_rx != 16'h0000) && (fold2 != 16'hFFFF))
      err_fin = 3'd4;
    else if (bus.port_hit == '0)
      err_fin = 3'd5;
    else
      err_fin = 3'd0;
  end

  // Segment FSM with registered outputs; DONE may start the next segment directly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      acc               <= '0;
      cnt               <= '0;
      csum_rx           <= '0;
      rem               <= '0;
      bus.src_port_udp  <= '0;
      bus.dest_port_udp <= '0;
      bus.len_udp_data  <= '0;
      bus.data_udp_out  <= '0;
      bus.wr_en_udp     <= 1'b0;
      bus.byte_en       <= '0;
      bus.port_hit      <= '0;
      bus.ok_udp        <= 1'b0;
      bus.fin_udp       <= 1'b0;
      bus.err_code      <= '0;
    end else begin
      bus.wr_en_udp <= 1'b0;
      bus.fin_udp   <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            bus.src_port_udp  <= bus.data[31:16];
            bus.dest_port_udp <= bus.data[15:0];
            bus.port_hit      <= hit_nxt;
            bus.len_udp_data  <= '0;
            bus.err_code      <= '0;
            bus.ok_udp        <= 1'b0;
            acc               <= w0_sum;
            state             <= HDR1;
          end else begin
            state <= IDLE;
          end
        end
        HDR1: begin
          if (!bus.start) begin
            bus.err_code <= 3'd3;
            state        <= CHECK;
          end else begin
            bus.len_udp_data <= len_f - 16'd8;
            csum_rx          <= bus.data[15:0];
            rem              <= len_f[1:0];
            // length appears in both the pseudo-header and the UDP header
            acc              <= acc + {16'b0, len_f} + {16'b0, len_f} + {16'b0, bus.data[15:0]};
            if (len_f < 16'd8) begin
              bus.err_code <= 3'd1;
              state        <= CHECK;
            end else if (len_f > 16'(MAX_LEN)) begin
              bus.err_code <= 3'd2;
              state        <= CHECK;
            end else if (len_f == 16'd8) begin
              state <= CHECK;
            end else begin
              cnt   <= words;
              state <= PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (!bus.start) begin
            bus.err_code <= 3'd3;
            state        <= CHECK;
          end else begin
            bus.data_udp_out <= bus.data;
            bus.wr_en_udp    <= 1'b1;
            bus.byte_en      <= (cnt == 16'd1) ? be_last : 4'hF;
            acc              <= acc + {16'b0, pay_m[31:16]} + {16'b0, pay_m[15:0]};
            cnt              <= cnt - 16'd1;
            if (cnt == 16'd1) state <= CHECK;
          end
        end
        CHECK: begin
          bus.err_code <= err_fin;
          bus.ok_udp   <= (err_fin == 3'd0);
          bus.fin_udp  <= 1'b1;
          state        <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_rx_decoder.sv
// Directed-vector bench for udp_rx_decoder: table of segments plus reset/back-to-back sequences.
// Latency: checks fin_udp timing relative to the last sampled word.
// Backpressure: none exercised; the decoder has no stall path.
module tb_udp_rx_decoder;

  localparam logic [31:0] SIP  = 32'hC0A8_0001;
  localparam logic [31:0] DIP  = 32'hC0A8_0002;
  localparam logic [63:0] PTBL = {16'h0007, 16'h01BB, 16'h0050, 16'h0035};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  udp_rx_decoder_if #(.NUM_PORTS(4)) bus ();

  udp_rx_decoder #(.NUM_PORTS(4), .MAX_LEN(1480), .CHK_EN(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0][31:0] w;
    int               nw;
    int               csm;   // 0: checksum as given, 1: computed, 2: computed+1
    logic [2:0]       err;
    logic             ok;
    logic [15:0]      len;
    logic [15:0]      sp;
    logic [15:0]      dp;
    logic [3:0]       hit;
    int               nwr;
    logic [3:0]       be;
    logic [31:0]      d0;
    int               lat;
  } vec_t;

  vec_t vt[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Monitor: records every payload write and every fin_udp cycle.
  int          mon_nwr = 0;
  int          mon_fin = 0;
  logic [31:0] wr_dat [256];
  logic [3:0]  wr_be  [256];
  always @(negedge clk) begin
    if (bus.wr_en_udp === 1'b1) begin
      wr_dat[mon_nwr[7:0]] = bus.data_udp_out;
      wr_be[mon_nwr[7:0]]  = bus.byte_en;
      mon_nwr++;
    end
    if (bus.fin_udp === 1'b1) mon_fin++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] w0, w1, w2, w3, input int nw, csm,
                     input logic [2:0] err, input logic ok, input logic [15:0] len, sp, dp,
                     input logic [3:0] hit, input int nwr, input logic [3:0] be,
                     input logic [31:0] d0, input int lat);
    vec_t v;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    v.nw = nw; v.csm = csm; v.err = err; v.ok = ok; v.len = len; v.sp = sp; v.dp = dp;
    v.hit = hit; v.nwr = nwr; v.be = be; v.d0 = d0; v.lat = lat;
    vt.push_back(v);
  endtask

  // RFC 768 checksum over pseudo-header, header (checksum zero) and up to 8 payload bytes.
  function automatic logic [15:0] udp_cs(input logic [31:0] w0, w1, p0, p1);
    logic [31:0] s;
    logic [63:0] pl;
    logic [7:0]  hi, lo;
    int          nb;
    pl = {p0, p1};
    nb = int'(w1[31:16]) - 8;
    s  = 32'(SIP[31:16]) + 32'(SIP[15:0]) + 32'(DIP[31:16]) + 32'(DIP[15:0]) + 32'h11
       + 32'(w1[31:16]) + 32'(w0[31:16]) + 32'(w0[15:0]) + 32'(w1[31:16]);
    for (int i = 0; i < 4; i++) begin
      hi = (2*i < nb)     ? pl[63-16*i -: 8] : 8'h00;
      lo = (2*i + 1 < nb) ? pl[55-16*i -: 8] : 8'h00;
      s  = s + {16'b0, hi, lo};
    end
    s = {16'b0, s[15:0]} + {16'b0, s[31:16]};
    s = {16'b0, s[15:0]} + {16'b0, s[31:16]};
    return ~s[15:0];
  endfunction

  task automatic send(input logic [15:0][31:0] ws, input int nw, output int lat);
    for (int j = 0; j < nw; j++) begin
      bus.data  = ws[j];
      bus.start = 1'b1;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    bus.data  = '0;
    lat = 0;
    while (bus.fin_udp !== 1'b1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t             v;
    logic [15:0][31:0] ws;
    logic [15:0]      cs;
    int               lat, b_nwr, b_fin, dn;
    logic [3:0]       lbe;
    logic [31:0]      fd;

    //   w0            w1            w2            w3          nw csm err ok len      sp       dp       hit     nwr be      d0            lat
    add(32'h1F900035, 32'h000C0000, 32'hDEADBEEF, 32'h0,       3, 0, 3'd0, 1, 16'h0004, 16'h1F90, 16'h0035, 4'b0001, 1, 4'hF,  32'hDEADBEEF, 1);
    add(32'h1F900035, 32'h000B0000, 32'hAABBCCDD, 32'h0,       3, 0, 3'd0, 1, 16'h0003, 16'h1F90, 16'h0035, 4'b0001, 1, 4'hE,  32'hAABBCCDD, 1);
    add(32'h30390050, 32'h00100000, 32'h01020304, 32'h05060708, 4, 1, 3'd0, 1, 16'h0008, 16'h3039, 16'h0050, 4'b0010, 2, 4'hF,  32'h01020304, 1);
    add(32'h30390050, 32'h00100000, 32'h01020304, 32'h05060708, 4, 2, 3'd4, 0, 16'h0008, 16'h3039, 16'h0050, 4'b0010, 2, 4'hF,  32'h01020304, 1);
    add(32'h1F900035, 32'h00060000, 32'h0,        32'h0,       2, 0, 3'd1, 0, 16'hFFFE, 16'h1F90, 16'h0035, 4'b0001, 0, 4'h0,  32'h0,        1);
    add(32'h1F900035, 32'h05C90000, 32'h0,        32'h0,       2, 0, 3'd2, 0, 16'h05C1, 16'h1F90, 16'h0035, 4'b0001, 0, 4'h0,  32'h0,        1);
    add(32'h1F901234, 32'h000C0000, 32'h11223344, 32'h0,       3, 0, 3'd5, 0, 16'h0004, 16'h1F90, 16'h1234, 4'b0000, 1, 4'hF,  32'h11223344, 1);
    add(32'h1F900035, 32'h00080000, 32'h0,        32'h0,       2, 0, 3'd0, 1, 16'h0000, 16'h1F90, 16'h0035, 4'b0001, 0, 4'h0,  32'h0,        1);
    add(32'h04D201BB, 32'h000D0000, 32'h11223344, 32'h55AABBCC, 4, 1, 3'd0, 1, 16'h0005, 16'h04D2, 16'h01BB, 4'b0100, 2, 4'h8,  32'h11223344, 1);
    add(32'h1F900035, 32'h00140000, 32'hCAFEF00D, 32'h0,       3, 0, 3'd3, 0, 16'h000C, 16'h1F90, 16'h0035, 4'b0001, 1, 4'hF,  32'hCAFEF00D, 2);
    add(32'h1F900035, 32'h0,        32'h0,        32'h0,       1, 0, 3'd3, 0, 16'h0000, 16'h1F90, 16'h0035, 4'b0001, 0, 4'h0,  32'h0,        2);

    reset = 1'b0;
    bus.start = 1'b0; bus.data = '0;
    bus.src_ip = SIP; bus.dest_ip = DIP; bus.port_tbl = PTBL;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hdr", 64'({bus.src_port_udp, bus.dest_port_udp, bus.len_udp_data}), 64'h0);
    chk("reset_flags", 64'({bus.data_udp_out, bus.wr_en_udp, bus.byte_en, bus.port_hit,
                            bus.ok_udp, bus.fin_udp, bus.err_code}), 64'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vt.size(); i++) begin
      v = vt[i];
      if (v.csm != 0) begin
        cs = udp_cs(v.w[0], v.w[1], v.w[2], v.w[3]) + 16'(v.csm - 1);
        v.w[1][15:0] = cs;
      end
      ws = '0;
      for (int j = 0; j < 4; j++) ws[j] = v.w[j];
      b_nwr = mon_nwr; b_fin = mon_fin;
      send(ws, v.nw, lat);
      dn  = mon_nwr - b_nwr;
      lbe = (dn > 0) ? wr_be[8'(mon_nwr - 1)] : 4'h0;
      fd  = (dn > 0) ? wr_dat[b_nwr[7:0]] : 32'h0;
      chk($sformatf("v%0d_fin_latency", i), 64'(lat), 64'(v.lat));
      chk($sformatf("v%0d_err_code", i), 64'(bus.err_code), 64'(v.err));
      chk($sformatf("v%0d_ok_udp", i), 64'(bus.ok_udp), 64'(v.ok));
      chk($sformatf("v%0d_len_udp_data", i), 64'(bus.len_udp_data), 64'(v.len));
      chk($sformatf("v%0d_ports", i), 64'({bus.src_port_udp, bus.dest_port_udp}), 64'({v.sp, v.dp}));
      chk($sformatf("v%0d_port_hit", i), 64'(bus.port_hit), 64'(v.hit));
      chk($sformatf("v%0d_wr_count", i), 64'(dn), 64'(v.nwr));
      chk($sformatf("v%0d_last_byte_en", i), 64'(lbe), 64'(v.be));
      chk($sformatf("v%0d_first_data", i), 64'(fd), 64'(v.d0));
      repeat (2) begin @(posedge clk); #1; end
      chk($sformatf("v%0d_ok_held", i), 64'(bus.ok_udp), 64'(v.ok));
      chk($sformatf("v%0d_fin_one_cycle", i), 64'(mon_fin - b_fin), 64'd1);
    end

    // Reset asserted in PAYLOAD: outputs clear at once and the segment never finishes.
    b_fin = mon_fin;
    bus.data = 32'h1F900035; bus.start = 1'b1; @(posedge clk); #1;
    bus.data = 32'h00140000;                   @(posedge clk); #1;
    bus.data = 32'h12345678;                   @(posedge clk); #1;
    chk("rst_mid_wr_before", 64'(bus.wr_en_udp), 64'd1);
    reset = 1'b0;
    bus.start = 1'b0; bus.data = '0;
    #1;
    chk("rst_mid_hdr", 64'({bus.src_port_udp, bus.dest_port_udp, bus.len_udp_data}), 64'h0);
    chk("rst_mid_flags", 64'({bus.data_udp_out, bus.wr_en_udp, bus.byte_en, bus.port_hit,
                              bus.ok_udp, bus.fin_udp, bus.err_code}), 64'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    chk("rst_mid_no_fin", 64'(mon_fin - b_fin), 64'd0);
    ws = '0;
    ws[0] = 32'h1F900035; ws[1] = 32'h000C0000; ws[2] = 32'hDEADBEEF;
    b_nwr = mon_nwr;
    send(ws, 3, lat);
    chk("post_rst_fin_latency", 64'(lat), 64'd1);
    chk("post_rst_ok", 64'({bus.ok_udp, bus.err_code}), 64'({1'b1, 3'd0}));
    chk("post_rst_len", 64'(bus.len_udp_data), 64'h4);
    chk("post_rst_data", 64'(wr_dat[b_nwr[7:0]]), 64'hDEADBEEF);
    repeat (2) begin @(posedge clk); #1; end

    // Back-to-back: start held high; one ignored word during CHECK, next header during DONE.
    cs = udp_cs(32'h30390050, 32'h00100000, 32'h01020304, 32'h05060708);
    ws = '0;
    ws[0] = 32'h1F900035; ws[1] = 32'h000C0000; ws[2] = 32'hDEADBEEF; ws[3] = 32'hFFFFFFFF;
    ws[4] = 32'h30390050; ws[5] = {16'h0010, cs}; ws[6] = 32'h01020304; ws[7] = 32'h05060708;
    b_nwr = mon_nwr; b_fin = mon_fin;
    send(ws, 8, lat);
    chk("b2b_fin_latency", 64'(lat), 64'd1);
    chk("b2b_ok", 64'({bus.ok_udp, bus.err_code}), 64'({1'b1, 3'd0}));
    chk("b2b_hdr", 64'({bus.dest_port_udp, bus.len_udp_data}), 64'({16'h0050, 16'h0008}));
    repeat (2) begin @(posedge clk); #1; end
    chk("b2b_fin_pulses", 64'(mon_fin - b_fin), 64'd2);
    chk("b2b_wr_count", 64'(mon_nwr - b_nwr), 64'd3);
    chk("b2b_second_data", 64'(wr_dat[8'(b_nwr + 1)]), 64'h01020304);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/udp_rx_decoder.md
UDP_RX_DECODER -- requirements
Module: udp_rx_decoder

Interface
REQ-001 Parameter NUM_PORTS, default 4: number of destination-port match entries (1..8).
REQ-002 Parameter MAX_LEN, default 1480: largest UDP length field accepted, in bytes.
REQ-003 Parameter CHK_EN, default 1: 1 enables checksum verification; 0 skips it.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; asserted (0) clears all state immediately.
REQ-006 data  input  32  UDP segment word, big-endian; sampled when start=1.
REQ-007 start  input  1  word-valid; held high for every consecutive word of one segment.
REQ-008 src_ip, dest_ip  input  32 each  IP addresses for pseudo-header; stable while start=1.
REQ-009 port_tbl  input  16*NUM_PORTS  destination-port match table; entry k at bits [16k+15:16k].
REQ-010 src_port_udp, dest_port_udp, len_udp_data  output  16 each  decoded header; len_udp_data = length field - 8.
REQ-011 data_udp_out  output  32  payload word; wr_en_udp  output  1  payload word valid.
REQ-012 byte_en  output  4  valid bytes of data_udp_out, MSB-first; 4'b1111 except on the final partial word.
REQ-013 port_hit  output  NUM_PORTS  one-hot/multi-hot match of dest_port_udp against port_tbl.
REQ-014 ok_udp  output  1  segment accepted; fin_udp  output  1  segment done; err_code  output  3  failure cause.

Function
REQ-015 States: IDLE, HDR1, PAYLOAD, CHECK, DONE; DONE returns to IDLE when start=0, or goes straight to HDR1 when start=1.
REQ-016 IDLE with start=1: capture data[31:16] as src_port_udp and data[15:0] as dest_port_udp, compute port_hit, go to HDR1.
REQ-017 HDR1 with start=1: capture length and checksum from data[31:16] and data[15:0].
REQ-018 HDR1: length<8 gives err_code 1, and length>MAX_LEN gives err_code 2; either goes to CHECK.
REQ-019 HDR1: length==8 goes to CHECK; otherwise load the word counter with ceil((length-8)/4) and go to PAYLOAD.
REQ-020 PAYLOAD: each start=1 cycle registers data to data_udp_out with wr_en_udp=1 the following cycle and decrements the counter.
REQ-021 The PAYLOAD word that brings the counter to 0 goes to CHECK; byte_en on it is 4'b1111 when (length-8) mod 4 = 0, else the top ((length-8) mod 4) bits set.
REQ-022 Words arriving after the counter reaches 0 are ignored; no wr_en_udp is issued for them.
REQ-023 start=0 in HDR1 or in PAYLOAD with counter>0 sets err_code 3 (truncated) and goes to CHECK.
REQ-024 Checksum uses a 32-bit one's-complement accumulator over src_ip, dest_ip, 16'h0011, the length field, both header words (checksum field included) and payload.
REQ-025 Payload bytes beyond length are zeroed before accumulation; the carry is folded twice in CHECK.
REQ-026 A folded sum other than 16'hFFFF gives err_code 4, unless the received checksum is 16'h0000 or CHK_EN=0.
REQ-027 port_hit all zero gives err_code 5.
REQ-028 Only the first detected error is recorded; priority is 1, 2, 3, 4, 5.
REQ-029 CHECK lasts exactly one cycle, then DONE; fin_udp pulses high for exactly the one cycle after CHECK.
REQ-030 ok_udp is set with fin_udp iff err_code=0 and stays held until the next segment's first word.
REQ-031 Header outputs and err_code hold from capture until the next segment's first word.
REQ-032 Latency: fin_udp is asserted 2 cycles after the last accepted word is sampled.

Reset
REQ-033 On reset=0 all outputs go to 0 and the state goes to IDLE, including mid-segment.
REQ-034 After reset is released, the first start=1 word is treated as header word 0.
REQ-035 An aborted segment produces no fin_udp.

Verification
REQ-036 Header 0x1F90_0035, 0x000C_0000, payload 0xDEADBEEF, port_tbl entry0=0x0035 -> wr_en_udp 1 cycle with byte_en=4'hF, len_udp_data=4, port_hit=4'b0001, ok_udp=1 with fin_udp.
REQ-037 Length 0x000B, checksum 0, payload 0xAABBCCDD -> data 0xAABBCCDD, byte_en=4'b1110, ok_udp=1.
REQ-038 Length 0x0010 with a bench-computed correct checksum -> ok_udp=1; same segment with checksum+1 -> err_code=4, ok_udp=0.
REQ-039 Length 0x0014 and start dropped after 1 payload word -> err_code=3 and a fin_udp pulse; length 0x0006 -> err_code=1 with no wr_en_udp.
REQ-040 reset pulsed low during PAYLOAD -> all outputs 0 at once, no fin_udp; the next segment decodes correctly.
REQ-041 dest port 0x1234 absent from port_tbl -> port_hit=0, err_code=5; back-to-back segments with no idle cycle -> two separate fin_udp pulses.
